// File: rtl/uart_fifo_ctl_pkg.sv
// Shared constants for the uart FIFO controller: register maps on both sides, status bit
// positions and the sequencer state encoding.
package uart_fifo_ctl_pkg;

  typedef logic [3:0] addr_t;
  typedef logic [7:0] byte_t;

  localparam addr_t UART_RX_ADDR    = 4'd0;
  localparam addr_t UART_TX_ADDR    = 4'd1;
  localparam addr_t UART_STAT_ADDR  = 4'd2;
  localparam addr_t UART_INV_ADDR   = 4'd3;
  localparam addr_t UART_DIVLO_ADDR = 4'd4;
  localparam addr_t UART_DIVHI_ADDR = 4'd5;

  localparam addr_t CPU_DATA_ADDR  = 4'd0;
  localparam addr_t CPU_TX_ADDR    = 4'd1;
  localparam addr_t CPU_STAT_ADDR  = 4'd2;
  localparam addr_t CPU_INV_ADDR   = 4'd3;
  localparam addr_t CPU_DIVLO_ADDR = 4'd4;
  localparam addr_t CPU_DIVHI_ADDR = 4'd5;
  localparam addr_t CPU_IE_ADDR    = 4'd6;

  localparam int STS_RX_NONEMPTY = 0;
  localparam int STS_RX_FULL     = 1;
  localparam int STS_TX_EMPTY    = 2;
  localparam int STS_TX_FULL     = 3;
  localparam int STS_TX_BUSY     = 4;
  localparam int STS_RX_OVF      = 5;
  localparam int STS_TX_OVF      = 6;

  localparam byte_t DIVLO_RESET = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    STAT,
    RXRD,
    TXCLR,
    TXWR
  } state_e;

endpackage

// File: rtl/uart_fifo_ctl_if.sv
// Signal bundle for the CPU io bus and the uart io port; the controller uses the slave view,
// whatever surrounds it (CPU plus uart) uses the master view.
interface uart_fifo_ctl_if;
  import uart_fifo_ctl_pkg::*;

  addr_t io_addr;
  byte_t io_wdata;
  logic  io_write;
  logic  io_read;
  byte_t io_rdata;
  logic  interrupt;
  addr_t u_addr;
  byte_t u_wdata;
  logic  u_write;
  logic  u_read;
  byte_t u_rdata;
  logic  u_interrupt;

  modport slave (
    input  io_addr, io_wdata, io_write, io_read, u_rdata, u_interrupt,
    output io_rdata, interrupt, u_addr, u_wdata, u_write, u_read
  );

  modport master (
    output io_addr, io_wdata, io_write, io_read, u_rdata, u_interrupt,
    input  io_rdata, interrupt, u_addr, u_wdata, u_write, u_read
  );

endinterface

// File: rtl/uart_fifo_ctl_sync_fifo.sv
// Single-clock FIFO with combinational head; a push into a full FIFO is still taken when a
// pop happens in the same cycle, otherwise it is dropped and flagged on drop_o.
module uart_fifo_ctl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);
  assign drop_o  = push_i & ~doPush;

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + 1'b1;
    end else if (doPop && !doPush) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/uart_fifo_ctl.sv
// Sequencer between the CPU io bus and one uart: TX/RX byte FIFOs, config shadows forwarded
// on demand, and a polling FSM that services the uart interrupt one register access per cycle.
module uart_fifo_ctl
  import uart_fifo_ctl_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input logic            clk,
  input logic            reset,
  uart_fifo_ctl_if.slave bus
);

  state_e     state_q, state_d;
  logic       txBusy_q, txBusy_d;
  logic       txOvf_q, txOvf_d;
  logic       rxOvf_q, rxOvf_d;
  logic [2:0] pend_q, pend_d;
  logic [1:0] ie_q, ie_d;
  logic [1:0] st_q, st_d;
  logic [1:0] inv_q, inv_d;
  byte_t      divLo_q, divLo_d;
  logic [3:0] divHi_q, divHi_d;

  logic  txPush, txPop, txFull, txEmpty, txDrop;
  logic  rxPush, rxPop, rxFull, rxEmpty, rxDrop;
  byte_t txHead, rxHead;

  logic       uWrite, uRead;
  addr_t      uAddr;
  byte_t      uWdata;
  logic [2:0] pendClr;
  logic       busySet, busyClr;
  byte_t      status, rdata;

  assign txPush = bus.io_write & (bus.io_addr == CPU_TX_ADDR);
  assign rxPop  = bus.io_read  & (bus.io_addr == CPU_DATA_ADDR);

  uart_fifo_ctl_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) txFifo (
    .clk(clk), .reset(reset), .push_i(txPush), .pop_i(txPop), .data_i(bus.io_wdata),
    .head_o(txHead), .full_o(txFull), .empty_o(txEmpty), .drop_o(txDrop)
  );

  uart_fifo_ctl_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rxFifo (
    .clk(clk), .reset(reset), .push_i(rxPush), .pop_i(rxPop), .data_i(bus.u_rdata),
    .head_o(rxHead), .full_o(rxFull), .empty_o(rxEmpty), .drop_o(rxDrop)
  );

  // Pending config writes win over interrupt service, which wins over starting a new byte.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    uWrite  = 1'b0;
    uRead   = 1'b0;
    uAddr   = '0;
    uWdata  = '0;
    txPop   = 1'b0;
    rxPush  = 1'b0;
    pendClr = '0;
    busySet = 1'b0;
    busyClr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0)                state_d = CFG;
        else if (bus.u_interrupt)        state_d = STAT;
        else if (!txBusy_q && !txEmpty)  state_d = TXWR;
      end
      CFG: begin
        uWrite  = 1'b1;
        state_d = IDLE;
        if (pend_q[0]) begin
          uAddr   = UART_INV_ADDR;
          uWdata  = {6'b0, inv_q};
          pendClr = 3'b001;
        end else if (pend_q[1]) begin
          uAddr   = UART_DIVLO_ADDR;
          uWdata  = divLo_q;
          pendClr = 3'b010;
        end else begin
          uAddr   = UART_DIVHI_ADDR;
          uWdata  = {4'b0, divHi_q};
          pendClr = 3'b100;
        end
      end
      STAT: begin
        uRead = 1'b1;
        uAddr = UART_STAT_ADDR;
        st_d  = bus.u_rdata[1:0];
        if (bus.u_rdata[1])      state_d = RXRD;
        else if (bus.u_rdata[0]) state_d = TXCLR;
        else                     state_d = IDLE;
      end
      RXRD: begin
        uRead   = 1'b1;
        uAddr   = UART_RX_ADDR;
        rxPush  = 1'b1;
        state_d = st_q[0] ? TXCLR : IDLE;
      end
      TXCLR: begin
        uWrite  = 1'b1;
        uAddr   = UART_STAT_ADDR;
        uWdata  = 8'h01;
        busyClr = 1'b1;
        state_d = IDLE;
      end
      TXWR: begin
        uWrite  = 1'b1;
        uAddr   = UART_TX_ADDR;
        uWdata  = txHead;
        txPop   = 1'b1;
        busySet = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A CPU shadow write re-arms its pend bit even when CFG clears it on the same edge.
  always_comb begin
    txBusy_d = txBusy_q;
    txOvf_d  = txOvf_q;
    rxOvf_d  = rxOvf_q;
    pend_d   = pend_q & ~pendClr;
    ie_d     = ie_q;
    inv_d    = inv_q;
    divLo_d  = divLo_q;
    divHi_d  = divHi_q;
    if (busySet)      txBusy_d = 1'b1;
    else if (busyClr) txBusy_d = 1'b0;
    if (bus.io_write) begin
      unique case (bus.io_addr)
        CPU_STAT_ADDR: begin
          if (bus.io_wdata[5]) rxOvf_d = 1'b0;
          if (bus.io_wdata[6]) txOvf_d = 1'b0;
        end
        CPU_INV_ADDR: begin
          inv_d     = bus.io_wdata[1:0];
          pend_d[0] = 1'b1;
        end
        CPU_DIVLO_ADDR: begin
          divLo_d   = bus.io_wdata;
          pend_d[1] = 1'b1;
        end
        CPU_DIVHI_ADDR: begin
          divHi_d   = bus.io_wdata[3:0];
          pend_d[2] = 1'b1;
        end
        CPU_IE_ADDR: ie_d = bus.io_wdata[1:0];
        default: ;
      endcase
    end
    if (txDrop) txOvf_d = 1'b1;
    if (rxDrop) rxOvf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      txBusy_q <= 1'b0;
      txOvf_q  <= 1'b0;
      rxOvf_q  <= 1'b0;
      pend_q   <= '0;
      ie_q     <= '0;
      st_q     <= '0;
      inv_q    <= '0;
      divLo_q  <= DIVLO_RESET;
      divHi_q  <= '0;
    end else begin
      state_q  <= state_d;
      txBusy_q <= txBusy_d;
      txOvf_q  <= txOvf_d;
      rxOvf_q  <= rxOvf_d;
      pend_q   <= pend_d;
      ie_q     <= ie_d;
      st_q     <= st_d;
      inv_q    <= inv_d;
      divLo_q  <= divLo_d;
      divHi_q  <= divHi_d;
    end
  end

  always_comb begin
    status                  = '0;
    status[STS_RX_NONEMPTY] = ~rxEmpty;
    status[STS_RX_FULL]     = rxFull;
    status[STS_TX_EMPTY]    = txEmpty;
    status[STS_TX_FULL]     = txFull;
    status[STS_TX_BUSY]     = txBusy_q;
    status[STS_RX_OVF]      = rxOvf_q;
    status[STS_TX_OVF]      = txOvf_q;
  end

  always_comb begin
    rdata = '0;
    unique case (bus.io_addr)
      CPU_DATA_ADDR:  rdata = rxEmpty ? 8'h00 : rxHead;
      CPU_STAT_ADDR:  rdata = status;
      CPU_INV_ADDR:   rdata = {6'b0, inv_q};
      CPU_DIVLO_ADDR: rdata = divLo_q;
      CPU_DIVHI_ADDR: rdata = {4'b0, divHi_q};
      CPU_IE_ADDR:    rdata = {6'b0, ie_q};
      default:        rdata = '0;
    endcase
  end

  assign bus.io_rdata  = rdata;
  assign bus.interrupt = (ie_q[0] & ~rxEmpty) | (ie_q[1] & txEmpty & ~txBusy_q);

  // The uart is held in reset from the same net, so its port is silenced immediately.
  assign bus.u_write = reset & uWrite;
  assign bus.u_read  = reset & uRead;
  assign bus.u_addr  = reset ? uAddr : 4'h0;
  assign bus.u_wdata = reset ? uWdata : 8'h00;

endmodule

// File: tb/tb_uart_fifo_ctl.sv
// Directed bench for uart_fifo_ctl; the uart side is a small register model driven from the
// same process as the CPU stimulus.
module tb_uart_fifo_ctl;

  localparam int TX_DEPTH = 8;
  localparam int RX_DEPTH = 8;

  logic clk = 1'b0;
  logic reset;

  uart_fifo_ctl_if bus();

  logic [7:0]  uRxByte;
  logic [1:0]  uSt;
  logic        autoTx;
  logic [11:0] wrLog[$];
  logic [7:0]  txBytes[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign bus.u_rdata     = (bus.u_addr == 4'd0) ? uRxByte :
                           (bus.u_addr == 4'd2) ? {6'b0, uSt} : 8'h00;
  assign bus.u_interrupt = |uSt;

  uart_fifo_ctl #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // One clock; the uart model commits whatever access the controller presented at the edge.
  task automatic step();
    logic       w, r;
    logic [3:0] a;
    logic [7:0] d;
    w = bus.u_write;
    r = bus.u_read;
    a = bus.u_addr;
    d = bus.u_wdata;
    @(posedge clk);
    #1;
    if (w) wrLog.push_back({a, d});
    if (r && a == 4'd0) uSt[1] = 1'b0;
    if (w && a == 4'd2) uSt = uSt & ~d[1:0];
    if (w && a == 4'd1 && autoTx) uSt[0] = 1'b1;
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
    bus.io_addr  = addr;
    bus.io_wdata = data;
    bus.io_write = 1'b1;
    step();
    bus.io_write = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.io_addr = 4'd0; bus.io_wdata = 8'h00; bus.io_write = 1'b0; bus.io_read = 1'b0;
    uSt = 2'b00; uRxByte = 8'h00; autoTx = 1'b0;
    step(); step();
    checks++;
    if ({bus.interrupt, bus.u_write, bus.u_read} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b want 000", {bus.interrupt, bus.u_write, bus.u_read});
    end
    reset = 1'b1;
    bus.io_addr = 4'd2; #1;
    checks++;
    if (bus.io_rdata !== 8'h04) begin errors++; $display("[TB] FAIL reset_status: got %h want 04", bus.io_rdata); end
    bus.io_addr = 4'd4; #1;
    checks++;
    if (bus.io_rdata !== 8'h01) begin errors++; $display("[TB] FAIL reset_divlo: got %h want 01", bus.io_rdata); end
    bus.io_addr = 4'd3; #1;
    checks++;
    if (bus.io_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_inv: got %h want 00", bus.io_rdata); end
  endtask

  task automatic test_tx();
    bus.io_addr = 4'd1; bus.io_write = 1'b1; bus.io_wdata = 8'h55;
    step();
    bus.io_wdata = 8'hA3;
    step();
    bus.io_write = 1'b0;
    checks++;
    if ({bus.u_write, bus.u_addr, bus.u_wdata} !== {1'b1, 4'd1, 8'h55}) begin
      errors++; $display("[TB] FAIL tx_first_write: got %b/%h/%h want 1/1/55", bus.u_write, bus.u_addr, bus.u_wdata);
    end
    step();
    bus.io_addr = 4'd2; #1;
    checks++;
    if (bus.io_rdata !== 8'h10) begin errors++; $display("[TB] FAIL tx_busy_status: got %h want 10", bus.io_rdata); end
    uSt = 2'b01;
    step();
    checks++;
    if ({bus.u_read, bus.u_addr} !== {1'b1, 4'd2}) begin
      errors++; $display("[TB] FAIL tx_stat_read: got %b/%h want 1/2", bus.u_read, bus.u_addr);
    end
    step();
    checks++;
    if ({bus.u_write, bus.u_addr, bus.u_wdata} !== {1'b1, 4'd2, 8'h01}) begin
      errors++; $display("[TB] FAIL tx_txclr: got %b/%h/%h want 1/2/01", bus.u_write, bus.u_addr, bus.u_wdata);
    end
    step(); step();
    checks++;
    if ({bus.u_write, bus.u_addr, bus.u_wdata} !== {1'b1, 4'd1, 8'hA3}) begin
      errors++; $display("[TB] FAIL tx_second_write: got %b/%h/%h want 1/1/a3", bus.u_write, bus.u_addr, bus.u_wdata);
    end
    step();
    uSt = 2'b01;
    step(); step(); step();
    checks++;
    if (bus.io_rdata !== 8'h04) begin errors++; $display("[TB] FAIL tx_done_status: got %h want 04", bus.io_rdata); end
  endtask

  task automatic test_rx();
    applyStimulus(4'd6, 8'h01);
    checks++;
    if (bus.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL rx_int_idle: got %b want 0", bus.interrupt); end
    uRxByte = 8'h3C; uSt = 2'b10;
    step(); step();
    checks++;
    if ({bus.u_read, bus.u_addr} !== {1'b1, 4'd0}) begin
      errors++; $display("[TB] FAIL rx_rxrd: got %b/%h want 1/0", bus.u_read, bus.u_addr);
    end
    step();
    checks++;
    if (bus.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL rx_int_set: got %b want 1", bus.interrupt); end
    bus.io_addr = 4'd2; #1;
    checks++;
    if (bus.io_rdata !== 8'h05) begin errors++; $display("[TB] FAIL rx_status: got %h want 05", bus.io_rdata); end
    bus.io_addr = 4'd0; bus.io_read = 1'b1; #1;
    checks++;
    if (bus.io_rdata !== 8'h3C) begin errors++; $display("[TB] FAIL rx_data: got %h want 3c", bus.io_rdata); end
    step();
    bus.io_read = 1'b0; #1;
    checks++;
    if ({bus.interrupt, bus.io_rdata} !== {1'b0, 8'h00}) begin
      errors++; $display("[TB] FAIL rx_after_pop: got %b/%h want 0/00", bus.interrupt, bus.io_rdata);
    end
    applyStimulus(4'd6, 8'h02);
    checks++;
    if ({bus.interrupt, bus.io_rdata} !== {1'b1, 8'h02}) begin
      errors++; $display("[TB] FAIL tx_empty_int: got %b/%h want 1/02", bus.interrupt, bus.io_rdata);
    end
    applyStimulus(4'd6, 8'h00);
  endtask

  task automatic test_tx_overflow();
    bus.io_addr = 4'd1; bus.io_write = 1'b1;
    for (int i = 0; i < TX_DEPTH + 2; i++) begin
      bus.io_wdata = 8'(8'h80 + i);
      step();
    end
    bus.io_write = 1'b0;
    bus.io_addr = 4'd2; #1;
    checks++;
    if (bus.io_rdata !== 8'h58) begin errors++; $display("[TB] FAIL txovf_status: got %h want 58", bus.io_rdata); end
    applyStimulus(4'd2, 8'h40);
    checks++;
    if (bus.io_rdata !== 8'h18) begin errors++; $display("[TB] FAIL txovf_clear: got %h want 18", bus.io_rdata); end
    wrLog.delete();
    autoTx = 1'b1; uSt = 2'b01;
    for (int i = 0; i < 60; i++) step();
    autoTx = 1'b0;
    txBytes.delete();
    foreach (wrLog[i]) if (wrLog[i][11:8] == 4'd1) txBytes.push_back(wrLog[i][7:0]);
    checks++;
    if (txBytes.size() != 8) begin errors++; $display("[TB] FAIL txovf_drain_count: got %0d want 8", txBytes.size()); end
    else begin
      checks++;
      if ({txBytes[0], txBytes[7]} !== 16'h8188) begin
        errors++; $display("[TB] FAIL txovf_drain_order: got %h..%h want 81..88", txBytes[0], txBytes[7]);
      end
    end
    #1;
    checks++;
    if (bus.io_rdata !== 8'h04) begin errors++; $display("[TB] FAIL txovf_idle_status: got %h want 04", bus.io_rdata); end
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i <= RX_DEPTH; i++) begin
      uRxByte = 8'(8'h10 + i); uSt = 2'b10;
      step(); step(); step();
    end
    bus.io_addr = 4'd2; #1;
    checks++;
    if (bus.io_rdata !== 8'h27) begin errors++; $display("[TB] FAIL rxovf_status: got %h want 27", bus.io_rdata); end
    bus.io_addr = 4'd0; #1;
    checks++;
    if (bus.io_rdata !== 8'h10) begin errors++; $display("[TB] FAIL rxovf_head: got %h want 10", bus.io_rdata); end
    applyStimulus(4'd2, 8'h20);
    checks++;
    if (bus.io_rdata !== 8'h07) begin errors++; $display("[TB] FAIL rxovf_clear: got %h want 07", bus.io_rdata); end
    bus.io_addr = 4'd0; bus.io_read = 1'b1;
    for (int i = 0; i < RX_DEPTH - 1; i++) step();
    checks++;
    if (bus.io_rdata !== 8'h17) begin errors++; $display("[TB] FAIL rxovf_last: got %h want 17", bus.io_rdata); end
    step();
    bus.io_read = 1'b0; #1;
    checks++;
    if (bus.io_rdata !== 8'h00) begin errors++; $display("[TB] FAIL rxovf_empty_read: got %h want 00", bus.io_rdata); end
  endtask

  task automatic test_config();
    uSt = 2'b01;
    step();
    bus.io_addr = 4'd4; bus.io_wdata = 8'h10; bus.io_write = 1'b1;
    step();
    bus.io_write = 1'b0; #1;
    checks++;
    if (bus.io_rdata !== 8'h10) begin errors++; $display("[TB] FAIL cfg_shadow_read: got %h want 10", bus.io_rdata); end
    bus.io_addr = 4'd5; bus.io_wdata = 8'h02; bus.io_write = 1'b1;
    step();
    bus.io_write = 1'b0;
    step();
    checks++;
    if ({bus.u_write, bus.u_addr, bus.u_wdata} !== {1'b1, 4'd4, 8'h10}) begin
      errors++; $display("[TB] FAIL cfg_divlo_fwd: got %b/%h/%h want 1/4/10", bus.u_write, bus.u_addr, bus.u_wdata);
    end
    step(); step();
    checks++;
    if ({bus.u_write, bus.u_addr, bus.u_wdata} !== {1'b1, 4'd5, 8'h02}) begin
      errors++; $display("[TB] FAIL cfg_divhi_fwd: got %b/%h/%h want 1/5/02", bus.u_write, bus.u_addr, bus.u_wdata);
    end
    step();
    bus.io_addr = 4'd3; bus.io_wdata = 8'h01; bus.io_write = 1'b1;
    step();
    bus.io_wdata = 8'h02;
    step();
    bus.io_write = 1'b0;
    checks++;
    if ({bus.u_write, bus.u_addr, bus.u_wdata} !== {1'b1, 4'd3, 8'h02}) begin
      errors++; $display("[TB] FAIL cfg_inv_latest: got %b/%h/%h want 1/3/02", bus.u_write, bus.u_addr, bus.u_wdata);
    end
    step();
    applyStimulus(4'd7, 8'hFF);
    checks++;
    if (bus.io_rdata !== 8'h00) begin errors++; $display("[TB] FAIL cfg_unmapped: got %h want 00", bus.io_rdata); end
  endtask

  task automatic test_reset_mid();
    bus.io_addr = 4'd1; bus.io_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.io_wdata = 8'(8'hC0 + i);
      step();
    end
    bus.io_write = 1'b0;
    uSt = 2'b01;
    step();
    reset = 1'b0; #1;
    checks++;
    if ({bus.u_read, bus.u_write, bus.u_addr, bus.u_wdata} !== 14'h0) begin
      errors++; $display("[TB] FAIL rst_mid_uport: got %b/%b/%h/%h want 0/0/0/00", bus.u_read, bus.u_write, bus.u_addr, bus.u_wdata);
    end
    step();
    uSt = 2'b00; reset = 1'b1;
    bus.io_addr = 4'd2; #1;
    checks++;
    if ({bus.interrupt, bus.io_rdata} !== {1'b0, 8'h04}) begin
      errors++; $display("[TB] FAIL rst_mid_status: got %b/%h want 0/04", bus.interrupt, bus.io_rdata);
    end
    wrLog.delete();
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (wrLog.size() != 0) begin errors++; $display("[TB] FAIL rst_mid_quiet: got %0d writes want 0", wrLog.size()); end
    applyStimulus(4'd1, 8'h5A);
    step();
    checks++;
    if ({bus.u_write, bus.u_addr, bus.u_wdata} !== {1'b1, 4'd1, 8'h5A}) begin
      errors++; $display("[TB] FAIL rst_mid_new_push: got %b/%h/%h want 1/1/5a", bus.u_write, bus.u_addr, bus.u_wdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_tx_overflow();
    test_rx_overflow();
    test_config();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
